// File: rtl/bus_pkg.sv
// ============================================================================
// Module      : bus_pkg
// Description : Shared widths, serial-frame constants and FSM states for the
//               master_port serial request engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bus_pkg;

    localparam int   ADDR_W     = 12;
    localparam int   DATA_W     = 8;
    localparam int   READY_GAP  = 3;
    localparam logic MODE_WRITE = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        GAP   = 3'd2,
        ADDR  = 3'd3,
        MODE  = 3'd4,
        WDATA = 3'd5,
        RWAIT = 3'd6,
        RDATA = 3'd7
    } state_e;

endpackage

`default_nettype wire

// File: rtl/master_port_if.sv
// ============================================================================
// Module      : master_port_if
// Description : Parallel request/response bundle between a host and the
//               master_port serial engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface master_port_if;
    import bus_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

`default_nettype wire

// File: rtl/master_port.sv
// ============================================================================
// Module      : master_port
// Description : Serialises read/write requests onto tx after a responder
//               handshake on rx, and collects read data back from rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module master_port
    import bus_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  wire logic    clk,
    input  wire logic    rst,
    master_port_if.slave bus,
    output logic         tx,
    input  wire logic    rx
);

    localparam int                TMR_W     = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(TIMEOUT - 1);
    localparam logic [3:0]        GAP_LAST  = 4'(READY_GAP - 1);
    localparam logic [3:0]        ADDR_LAST = 4'(ADDR_W - 1);
    localparam logic [3:0]        DATA_LAST = 4'(DATA_W - 1);

    state_e              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   sh_q, sh_d;
    logic                write_q, write_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                tx_q, tx_d;
    logic                resp_valid_q, resp_valid_d;
    logic                resp_err_q, resp_err_d;
    logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;

    logic                w_accept;
    logic [DATA_W-1:0]   w_rd_next;

    assign bus.req_ready  = (state_q == IDLE) && rx;
    assign w_accept       = bus.req_valid && bus.req_ready;
    // Read bits arrive LSB first, so each new bit enters at the top.
    assign w_rd_next      = {rx, sh_q[DATA_W-1:1]};

    assign tx             = tx_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_err   = resp_err_q;
    assign bus.resp_rdata = resp_rdata_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        cnt_d        = cnt_q;
        sh_d         = sh_q;
        write_d      = write_q;
        wdata_d      = wdata_q;
        tx_d         = tx_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;

        case (state_q)
            IDLE: begin
                if (w_accept) begin
                    write_d = bus.req_write;
                    wdata_d = bus.req_wdata;
                    sh_d    = bus.req_addr;
                    tx_d    = 1'b0;
                    timer_d = '0;
                    cnt_d   = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (!rx) begin
                    cnt_d   = '0;
                    state_d = GAP;
                end else if (timer_q == TMR_LAST) begin
                    tx_d         = 1'b1;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b1;
                    state_d      = IDLE;
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) begin
                    tx_d    = sh_q[0];
                    sh_d    = sh_q >> 1;
                    cnt_d   = '0;
                    state_d = ADDR;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ADDR: begin
                if (cnt_q == ADDR_LAST) begin
                    tx_d    = (write_q == MODE_WRITE);
                    cnt_d   = '0;
                    state_d = MODE;
                end else begin
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            MODE: begin
                cnt_d = '0;
                if (write_q == MODE_WRITE) begin
                    tx_d    = wdata_q[0];
                    sh_d    = {{(ADDR_W-DATA_W+1){1'b0}}, wdata_q[DATA_W-1:1]};
                    state_d = WDATA;
                end else begin
                    tx_d    = 1'b1;
                    state_d = RWAIT;
                end
            end
            WDATA: begin
                if (cnt_q == DATA_LAST) begin
                    tx_d         = 1'b1;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    tx_d  = sh_q[0];
                    sh_d  = sh_q >> 1;
                    cnt_d = cnt_q + 4'd1;
                end
            end
            RWAIT: begin
                cnt_d   = '0;
                state_d = RDATA;
            end
            RDATA: begin
                if (cnt_q == DATA_LAST) begin
                    resp_rdata_d = w_rd_next;
                    resp_valid_d = 1'b1;
                    state_d      = IDLE;
                end else begin
                    sh_d  = {{(ADDR_W-DATA_W){1'b0}}, w_rd_next};
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            timer_q      <= '0;
            cnt_q        <= '0;
            sh_q         <= '0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            tx_q         <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            cnt_q        <= cnt_d;
            sh_q         <= sh_d;
            write_q      <= write_d;
            wdata_q      <= wdata_d;
            tx_q         <= tx_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_master_port.sv
// ============================================================================
// Module      : tb_master_port
// Description : Randomised scoreboard bench for master_port with a
//               behavioural serial responder.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_master_port;
    import bus_pkg::*;

    localparam int TMO   = 255;
    localparam int TMO_S = 16;

    logic clk;
    logic rst;
    logic tx, rx;
    logic tx_s, rx_s;

    master_port_if bus();
    master_port_if bus_s();

    master_port #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst(rst), .bus(bus.slave), .tx(tx), .rx(rx)
    );

    master_port #(.TIMEOUT(TMO_S)) dut_s (
        .clk(clk), .rst(rst), .bus(bus_s.slave), .tx(tx_s), .rx(rx_s)
    );

    assign rx_s = 1'b1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [11:0] addr;
        logic [7:0]  wdata;
        int          busy;   // cycles the responder stalls; negative = never answers
        logic [7:0]  rdata;
        int          hold;   // cycles rx stays low after the transfer
    } cfg_t;

    typedef struct {
        bit         wr;
        bit         err;
        logic [7:0] rdata;
        int         lat;
    } exp_t;

    cfg_t       cfg_q[$];
    exp_t       exp_q[$];
    int         tests = 0;
    int         fails = 0;
    int         cyc   = 0;
    logic [7:0] model_rd;
    bit         rsp_abort;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Responder: one step per falling edge; a reset abandons the frame.
    task automatic rstep();
        @(negedge clk);
        if (rst) rsp_abort = 1'b1;
        if (rsp_abort) rx = 1'b1;
    endtask

    initial begin : responder
        cfg_t        c;
        logic [11:0] ga;
        logic [7:0]  gd;
        bit          gw;
        int          lowbad;
        int          n;
        rx = 1'b1;
        forever begin
            rsp_abort = 1'b0;
            rx        = 1'b1;
            do @(negedge clk); while (rst || tx !== 1'b0);
            if (cfg_q.size() == 0) begin
                check("start bit without request", 1, 0);
                while (tx !== 1'b1) @(negedge clk);
                continue;
            end
            c = cfg_q.pop_front();
            if (c.busy < 0) begin
                n = 0;
                while (tx !== 1'b1 && !rsp_abort && n < 1000) begin rstep(); n++; end
                continue;
            end
            lowbad = 0;
            repeat (c.busy) begin
                rstep();
                if (tx !== 1'b0 && !rsp_abort) lowbad++;
            end
            if (c.busy > 0 && !rsp_abort) check("tx low while responder busy", lowbad, 0);
            if (!rsp_abort) rx = 1'b0;
            rstep();
            rx = 1'b1;
            repeat (2) rstep();
            for (int k = 0; k < 12; k++) begin rstep(); ga[k] = tx; end
            rstep();
            gw = tx;
            if (!rsp_abort) begin
                check("responder address", ga, c.addr);
                check("responder mode bit", gw, c.wr);
            end
            if (c.wr) begin
                for (int i = 0; i < 8; i++) begin rstep(); gd[i] = tx; end
                if (!rsp_abort) check("responder write data", gd, c.wdata);
                rstep();
            end else begin
                rstep();
                if (!rsp_abort) check("tx high in read turnaround", tx, 1);
                for (int i = 0; i < 8; i++) begin
                    rstep();
                    if (!rsp_abort) rx = c.rdata[i];
                end
                rstep();
                rx = 1'b1;
            end
            if (c.hold > 0 && !rsp_abort) begin
                rx = 1'b0;
                repeat (c.hold) rstep();
                rx = 1'b1;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        bit   outst;
        int   acc;
        outst = 1'b0;
        acc   = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                exp_q.delete();
                outst = 1'b0;
                continue;
            end
            if (bus.resp_valid === 1'b1) begin
                if (!outst || exp_q.size() == 0) begin
                    check("resp_valid only once per request", 1, 0);
                end else begin
                    e     = exp_q.pop_front();
                    outst = 1'b0;
                    check("resp_err", bus.resp_err, e.err);
                    check("resp_rdata", bus.resp_rdata, e.rdata);
                    check("response latency", cyc - acc, e.lat);
                    check("tx idle at completion", tx, 1);
                end
            end
            if (bus.req_valid === 1'b1 && bus.req_ready === 1'b1) begin
                if (outst) check("no overlapping requests", 1, 0);
                check("rx high at acceptance", rx, 1);
                outst = 1'b1;
                acc   = cyc + 1;
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic issue(input bit wr, input logic [11:0] addr, input logic [7:0] wd,
                         input int busy, input logic [7:0] rd, input int hold, input bit keep);
        cfg_t c;
        exp_t e;
        int   n;
        n = 0;
        bus.req_write = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        #1;
        while (bus.req_ready !== 1'b1 && n < 2000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 2000) begin
            check("request accepted in time", 0, 1);
            bus.req_valid = 1'b0;
            return;
        end
        c      = '{wr, addr, wd, busy, rd, hold};
        e.wr   = wr;
        e.err  = (busy < 0);
        e.lat  = e.err ? TMO : busy + 25 + (wr ? 0 : 1);
        if (!wr && !e.err) model_rd = rd;
        e.rdata = model_rd;
        cfg_q.push_back(c);
        exp_q.push_back(e);
        @(negedge clk);
        if (!keep) bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) check("all responses returned", exp_q.size(), 0);
        repeat (4) @(negedge clk);
    endtask

    task automatic short_timeout();
        int bad;
        bad = 0;
        bus_s.req_write = 1'b1;
        bus_s.req_addr  = 12'h555;
        bus_s.req_wdata = 8'hAA;
        bus_s.req_valid = 1'b1;
        #1;
        check("short: req_ready when idle", bus_s.req_ready, 1);
        @(negedge clk);
        bus_s.req_valid = 1'b0;
        for (int k = 0; k < TMO_S; k++) begin
            if (bus_s.resp_valid !== 1'b0 || tx_s !== 1'b0) bad++;
            @(negedge clk);
        end
        check("short: quiet and tx low before timeout", bad, 0);
        check("short: resp_valid at timeout", bus_s.resp_valid, 1);
        check("short: resp_err at timeout", bus_s.resp_err, 1);
        check("short: tx high at timeout", tx_s, 1);
        check("short: resp_rdata untouched", bus_s.resp_rdata, 0);
        @(negedge clk);
        check("short: resp_valid single cycle", bus_s.resp_valid, 0);
        check("short: req_ready after timeout", bus_s.req_ready, 1);
    endtask

    initial begin : stimulus
        rst             = 1'b1;
        model_rd        = 8'h00;
        bus.req_valid   = 1'b0;
        bus.req_write   = 1'b0;
        bus.req_addr    = '0;
        bus.req_wdata   = '0;
        bus_s.req_valid = 1'b0;
        bus_s.req_write = 1'b0;
        bus_s.req_addr  = '0;
        bus_s.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("reset tx", tx, 1);
        check("reset resp_valid", bus.resp_valid, 0);
        check("reset resp_err", bus.resp_err, 0);
        check("reset resp_rdata", bus.resp_rdata, 0);
        check("reset req_ready", bus.req_ready, 1);
        rst = 1'b0;
        @(negedge clk);

        issue(1'b1, 12'hA5C, 8'h3C, 0, 8'h00, 0, 1'b0);
        issue(1'b0, 12'h001, 8'h00, 0, 8'hD3, 0, 1'b0);
        issue(1'b1, 12'h9E1, 8'hC5, 40, 8'h00, 0, 1'b0);
        issue(1'b0, 12'h2B4, 8'h00, 40, 8'h5A, 0, 1'b0);
        drain();

        issue(1'b0, 12'h7FF, 8'h00, -1, 8'h00, 0, 1'b0);
        drain();

        for (int t = 0; t < 24; t++) begin
            issue(1'($urandom_range(0, 1)), 12'($urandom), 8'($urandom),
                  int'($urandom_range(0, 4)), 8'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0,
                  $urandom_range(0, 3) != 0);
        end
        bus.req_valid = 1'b0;
        drain();

        issue(1'b1, 12'h3C3, 8'hF0, 0, 8'h00, 0, 1'b0);
        repeat (11) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("tx high on mid-frame reset", tx, 1);
        check("no resp_valid on mid-frame reset", bus.resp_valid, 0);
        @(negedge clk);
        @(negedge clk);
        rst      = 1'b0;
        model_rd = 8'h00;
        check("resp_rdata cleared by reset", bus.resp_rdata, 0);
        repeat (30) @(negedge clk);
        issue(1'b0, 12'h001, 8'h00, 0, 8'hD3, 0, 1'b0);
        drain();

        short_timeout();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/master_port.md
MASTER_PORT -- requirements
Module: master_port

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: max cycles in REQ waiting for responder ready.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port req_valid  input  1  request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when req_valid&&req_ready at edge.
REQ-006 SHALL have port req_write  input  1  1=write, 0=read.
REQ-007 SHALL have port req_addr  input  12  target address, sent LSB first.
REQ-008 SHALL have port req_wdata  input  8  write data, sent LSB first.
REQ-009 SHALL have port resp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL have port resp_rdata  output  8  read data, valid with resp_valid on reads.
REQ-011 SHALL have port resp_err  output  1  timeout flag, valid with resp_valid.
REQ-012 SHALL have port tx  output  1  serial line to responder rx, idle high.
REQ-013 SHALL have port rx  input  1  serial line from responder tx, idle high.

Function
REQ-014 SHALL implement states IDLE, REQ, GAP, ADDR, MODE, WDATA, RWAIT, RDATA.
REQ-015 SHALL drive req_ready = (state==IDLE) && rx; combinational, nothing else.
REQ-016 On acceptance SHALL latch write/addr/wdata, set tx=0 (start) at that edge, enter REQ, clear timer.
REQ-017 In REQ SHALL hold tx=0; first edge sampling rx==0 is edge R: enter GAP; else timer+1.
REQ-018 In REQ, timer reaching TIMEOUT SHALL set tx=1, pulse resp_valid with resp_err=1, return to IDLE.
REQ-019 GAP SHALL last so tx carries addr[0] from edge R+3.
REQ-020 ADDR SHALL update tx to addr[k] at edge R+3+k, k=0..11.
REQ-021 MODE SHALL drive tx=write flag at edge R+15.
REQ-022 Write: tx=wdata[i] at edge R+16+i, i=0..7; at R+24 tx=1, resp_valid=1, resp_err=0, IDLE.
REQ-023 Read: tx=1 at R+16; sample rx into resp_rdata[i] at edge R+18+i, i=0..7.
REQ-024 Read: resp_valid=1, resp_err=0 at edge R+25 with complete resp_rdata; then IDLE.
REQ-025 rx changes after edge R SHALL be ignored until return to IDLE (no abort).
REQ-026 resp_rdata SHALL hold its last value until the next read completes; unchanged by writes and timeouts.
REQ-027 resp_valid SHALL be high exactly one cycle per accepted request, never otherwise.
REQ-028 Timer width SHALL be $clog2(TIMEOUT+1); bit counter 4 bits, no wrap within a phase.

Reset
REQ-029 rst SHALL immediately force IDLE, tx=1, resp_valid=0, resp_err=0, resp_rdata=0, counters=0.
REQ-030 rst mid-transaction SHALL abandon it without a resp_valid pulse; tx high before next edge.

Structure
REQ-031 Shared package bus_pkg SHALL hold ADDR_W=12, DATA_W=8, READY_GAP=3, MODE_WRITE=1, state enum.
REQ-032 SHALL be one module; no sub-module (single FSM, shared bit counter, shift register, timer).

Verification
REQ-033 Write addr=12'hA5C, wdata=8'h3C, responder idle -> responder captures addr 12'hA5C, data 8'h3C; resp_valid at R+24, resp_err=0.
REQ-034 Read addr=12'h001, responder returns 8'hD3 -> resp_rdata=8'hD3 at R+25, resp_err=0.
REQ-035 Responder busy 40 cycles then ready, TIMEOUT=255 -> tx low throughout; transfer completes, edge R timing holds.
REQ-036 rx never goes low, TIMEOUT=16 -> resp_valid, resp_err=1 16 cycles after acceptance; tx=1; req_ready high next cycle.
REQ-037 rst asserted at R+10 of a write -> tx=1 immediately, no resp_valid; next read returns 8'hD3 correctly.
REQ-038 Back-to-back requests, req_valid held -> second accepted only once rx high; both complete, no overlap.
